// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for one shared single-port memory, one access in flight.
// Define MEM_ARB_RR_EN for round-robin; otherwise data has strict priority.
module mem_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   output logic        if_err,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [3:0]  d_be,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_e;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        rr_q, rr_d;
   logic [31:0] addr_q, addr_d;
   logic        we_q, we_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic        if_rvalid_q, if_rvalid_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic        if_err_q, if_err_d;
   logic        d_rvalid_q, d_rvalid_d;
   logic [31:0] d_rdata_q, d_rdata_d;
   logic        d_err_q, d_err_d;
   logic        pick_d, pick_if, done, busy;
   logic [31:0] ret_data;

   always_comb begin
`ifdef MEM_ARB_RR_EN
      pick_d = d_req & (~if_req | rr_q);
`else
      pick_d = d_req;
`endif
      pick_if = if_req & ~pick_d;
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rr_d        = rr_q;
      addr_d      = addr_q;
      we_d        = we_q;
      be_d        = be_q;
      wdata_d     = wdata_q;
      if_rvalid_d = 1'b0;
      if_rdata_d  = if_rdata_q;
      if_err_d    = if_err_q;
      d_rvalid_d  = 1'b0;
      d_rdata_d   = d_rdata_q;
      d_err_d     = d_err_q;
      if_gnt      = 1'b0;
      d_gnt       = 1'b0;
      // Ack beats timeout when both land in the same cycle.
      done        = mem_ack | (cnt_q == TO_LAST);
      ret_data    = (mem_ack & ~we_q) ? mem_rdata : 32'h0;
      unique case (state_q)
         IDLE: begin
            cnt_d = 8'h0;
            if (pick_d) begin
               d_gnt   = rst_n;
               state_d = BUSY_D;
               rr_d    = 1'b0;
               addr_d  = d_addr;
               we_d    = d_we;
               be_d    = d_be;
               wdata_d = d_wdata;
            end else if (pick_if) begin
               if_gnt  = rst_n;
               state_d = BUSY_IF;
               rr_d    = 1'b1;
               addr_d  = if_addr;
               we_d    = 1'b0;
               be_d    = 4'b1111;
               wdata_d = 32'h0;
            end
         end
         BUSY_IF: begin
            if (done) begin
               state_d     = IDLE;
               if_rvalid_d = 1'b1;
               if_rdata_d  = ret_data;
               if_err_d    = ~mem_ack;
            end else begin
               cnt_d = cnt_q + 8'h1;
            end
         end
         BUSY_D: begin
            if (done) begin
               state_d    = IDLE;
               d_rvalid_d = 1'b1;
               d_rdata_d  = ret_data;
               d_err_d    = ~mem_ack;
            end else begin
               cnt_d = cnt_q + 8'h1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= 8'h0;
         rr_q        <= 1'b1;
         addr_q      <= 32'h0;
         we_q        <= 1'b0;
         be_q        <= 4'h0;
         wdata_q     <= 32'h0;
         if_rvalid_q <= 1'b0;
         if_rdata_q  <= 32'h0;
         if_err_q    <= 1'b0;
         d_rvalid_q  <= 1'b0;
         d_rdata_q   <= 32'h0;
         d_err_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rr_q        <= rr_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         be_q        <= be_d;
         wdata_q     <= wdata_d;
         if_rvalid_q <= if_rvalid_d;
         if_rdata_q  <= if_rdata_d;
         if_err_q    <= if_err_d;
         d_rvalid_q  <= d_rvalid_d;
         d_rdata_q   <= d_rdata_d;
         d_err_q     <= d_err_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign mem_req   = busy;
   assign mem_we    = busy & we_q;
   assign mem_be    = busy ? be_q : 4'h0;
   assign mem_addr  = busy ? addr_q : 32'h0;
   assign mem_wdata = busy ? wdata_q : 32'h0;
   assign if_rvalid = if_rvalid_q;
   assign if_rdata  = if_rdata_q;
   assign if_err    = if_err_q;
   assign d_rvalid  = d_rvalid_q;
   assign d_rdata   = d_rdata_q;
   assign d_err     = d_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, arbitration order, store,
// timeout vs. ack, and reset during an access.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt, if_rvalid, if_err;
   logic [31:0] if_rdata;
   logic        d_req, d_we;
   logic [3:0]  d_be;
   logic [31:0] d_addr, d_wdata;
   logic        d_gnt, d_rvalid, d_err;
   logic [31:0] d_rdata;
   logic        mem_req, mem_we, mem_ack;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int checks   = 0;
   int failures = 0;

   mem_arbiter #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr),
      .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .if_rdata(if_rdata), .if_err(if_err),
      .d_req(d_req), .d_we(d_we), .d_be(d_be),
      .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid),
      .d_rdata(d_rdata), .d_err(d_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   logic exp_d [5];
   int   n;

   initial begin
`ifdef MEM_ARB_RR_EN
      exp_d = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
`else
      exp_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`endif
      rst_n = 1'b0;
      if_req = 1'b1; if_addr = 32'h0;
      d_req = 1'b1; d_we = 1'b0; d_be = 4'h0;
      d_addr = 32'h0; d_wdata = 32'h0;
      mem_ack = 1'b0; mem_rdata = 32'h0;
      #1;
      check("rst_if_gnt", 32'(if_gnt), 32'h0);
      check("rst_d_gnt", 32'(d_gnt), 32'h0);
      check("rst_mem_req", 32'(mem_req), 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_d_rvalid", 32'(d_rvalid), 32'h0);
      check("rst_if_rdata", if_rdata, 32'h0);
      @(negedge clk);
      if_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // single fetch, ack in the 3rd busy cycle
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h0000_0040;
      #1;
      check("f_if_gnt", 32'(if_gnt), 32'h1);
      check("f_d_gnt", 32'(d_gnt), 32'h0);
      @(negedge clk);
      if_req = 1'b0; if_addr = 32'hFFFF_FFFF;
      n = 0;
      for (int k = 1; k <= 3; k++) begin
         if (k > 1) @(negedge clk);
         if (mem_req) n++;
         check("f_gnt_busy", 32'(if_gnt), 32'h0);
         if (k == 3) begin
            mem_ack = 1'b1; mem_rdata = 32'h0000_0013;
         end
      end
      check("f_mem_addr", mem_addr, 32'h0000_0040);
      check("f_mem_be", 32'(mem_be), 32'hF);
      check("f_mem_we", 32'(mem_we), 32'h0);
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = 32'h0;
      check("f_req_cycles", 32'(n), 32'd3);
      check("f_mem_req_off", 32'(mem_req), 32'h0);
      check("f_rvalid", 32'(if_rvalid), 32'h1);
      check("f_rdata", if_rdata, 32'h0000_0013);
      check("f_err", 32'(if_err), 32'h0);
      @(negedge clk);
      check("f_rvalid_pulse", 32'(if_rvalid), 32'h0);
      check("f_rdata_hold", if_rdata, 32'h0000_0013);

      // arbitration order from a fresh reset
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         d_req = (i < 4); if_req = 1'b1;
         d_addr = 32'h100 + 32'(i); if_addr = 32'h200 + 32'(i);
         #1;
         check($sformatf("arb_d%0d", i), 32'(d_gnt), 32'(exp_d[i]));
         check($sformatf("arb_if%0d", i), 32'(if_gnt), 32'(!exp_d[i]));
         @(negedge clk);
         check("arb_busy_gnt", 32'(if_gnt | d_gnt), 32'h0);
         mem_ack = 1'b1; mem_rdata = 32'h10 + 32'(i);
         @(negedge clk);
         mem_ack = 1'b0;
         check($sformatf("arb_rv%0d", i),
               32'(exp_d[i] ? d_rvalid : if_rvalid), 32'h1);
         check($sformatf("arb_rd%0d", i),
               exp_d[i] ? d_rdata : if_rdata, 32'h10 + 32'(i));
      end
      if_req = 1'b0; d_req = 1'b0;

      // store
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011;
      d_addr = 32'h0000_0300; d_wdata = 32'hDEAD_BEEF;
      #1;
      check("st_gnt", 32'(d_gnt), 32'h1);
      @(negedge clk);
      d_req = 1'b0; d_we = 1'b0; d_wdata = 32'h0;
      check("st_mem_we", 32'(mem_we), 32'h1);
      check("st_mem_be", 32'(mem_be), 32'h3);
      check("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      check("st_mem_addr", mem_addr, 32'h0000_0300);
      mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
      @(negedge clk);
      mem_ack = 1'b0;
      check("st_rvalid", 32'(d_rvalid), 32'h1);
      check("st_rdata", d_rdata, 32'h0);
      check("st_err", 32'(d_err), 32'h0);

      // timeout with no ack
      @(negedge clk);
      d_req = 1'b1; d_be = 4'hF; d_addr = 32'h0000_0400;
      @(negedge clk);
      d_req = 1'b0;
      n = 0;
      for (int k = 0; k < 40; k++) begin
         if (!mem_req) break;
         n++;
         @(negedge clk);
      end
      check("to_cycles", 32'(n), 32'd16);
      check("to_rvalid", 32'(d_rvalid), 32'h1);
      check("to_err", 32'(d_err), 32'h1);
      check("to_rdata", d_rdata, 32'h0);
      @(negedge clk);
      check("to_err_hold", 32'(d_err), 32'h1);
      check("to_rvalid_pulse", 32'(d_rvalid), 32'h0);

      // ack in the 16th busy cycle wins over timeout
      d_req = 1'b1;
      @(negedge clk);
      d_req = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         if (k > 1) @(negedge clk);
         if (k == 16) begin
            check("ak_req16", 32'(mem_req), 32'h1);
            mem_ack = 1'b1; mem_rdata = 32'h0000_ABCD;
         end
      end
      @(negedge clk);
      mem_ack = 1'b0;
      check("ak_rvalid", 32'(d_rvalid), 32'h1);
      check("ak_err", 32'(d_err), 32'h0);
      check("ak_rdata", d_rdata, 32'h0000_ABCD);

      // reset during BUSY_D
      @(negedge clk);
      d_req = 1'b1;
      @(negedge clk);
      d_req = 1'b0;
      check("rm_busy", 32'(mem_req), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("rm_req_off", 32'(mem_req), 32'h0);
      check("rm_rdata_clr", d_rdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
      n = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (d_rvalid || mem_req) n++;
      end
      mem_ack = 1'b0;
      check("rm_stray_ack", 32'(n), 32'h0);
      check("rm_rdata", d_rdata, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
